// File: rtl/out_sig_pkg.sv
// Shared types and helpers for the output-signature collector.
// Holds the FSM state encoding, the default MISR constants and one MISR step.
package out_sig_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int SIG_W = 32;
    localparam logic [SIG_W-1:0] DEF_POLY = 32'h04C11DB7;
    localparam logic [SIG_W-1:0] DEF_SEED = 32'hFFFFFFFF;

    // Shift left, feed the MSB back through the polynomial, then mix in the nibble.
    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] sig,
                                                  input logic [3:0]       nibble,
                                                  input logic [SIG_W-1:0] poly);
        return {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? poly : '0) ^ {{(SIG_W-4){1'b0}}, nibble};
    endfunction

endpackage

// File: rtl/sig_misr.sv
// Working MISR signature register with seed load and fold enable.
// Exposes the value it will hold after this edge so a final beat can be latched with it.
module sig_misr
    import out_sig_pkg::*;
#(
    parameter int                   SIG_WIDTH = 32,
    parameter logic [SIG_WIDTH-1:0] POLY      = DEF_POLY,
    parameter logic [SIG_WIDTH-1:0] SEED      = DEF_SEED
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 en,
    input  logic [3:0]           nibble,
    output logic [SIG_WIDTH-1:0] sig_next
);

    logic [SIG_WIDTH-1:0] sig;
    logic [SIG_WIDTH-1:0] step;

    generate
        if (SIG_WIDTH == SIG_W) begin : g_pkg_step
            assign step = misr_step(sig, nibble, POLY);
        end else begin : g_generic_step
            assign step = {sig[SIG_WIDTH-2:0], 1'b0} ^ (sig[SIG_WIDTH-1] ? POLY : '0)
                        ^ SIG_WIDTH'(nibble);
        end
    endgenerate

    always_comb begin
        sig_next = sig;
        if (load) begin
            sig_next = SEED;
        end else if (en) begin
            sig_next = step;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= '0;
        end else begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/out_sig_collector.sv
// Folds the kernel's nibble output stream into a MISR signature per run, drains
// in-flight beats after ap_done, then latches signature, beat count and count check.
module out_sig_collector
    import out_sig_pkg::*;
#(
    parameter int                   SIG_WIDTH      = 32,
    parameter int                   CNT_WIDTH      = 16,
    parameter logic [SIG_WIDTH-1:0] POLY           = DEF_POLY,
    parameter logic [SIG_WIDTH-1:0] SEED           = DEF_SEED,
    parameter int                   EXPECTED_BEATS = 0,
    parameter int                   DRAIN_CYCLES   = 4
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic                 ap_start,
    input  logic                 ap_done,
    input  logic                 data_valid,
    input  logic [3:0]           data_out,
    output logic [SIG_WIDTH-1:0] sig_out,
    output logic [CNT_WIDTH-1:0] beat_cnt,
    output logic                 sig_valid,
    output logic                 cnt_err,
    output logic                 busy,
    output logic [7:0]           run_cnt
);

    localparam int                   DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0]   DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] EXP_CNT    = CNT_WIDTH'(EXPECTED_BEATS);
    localparam bit                   CHECK_EN   = (EXPECTED_BEATS != 0);

    state_t               state;
    state_t               state_nxt;
    logic                 start_q;
    logic                 start_edge;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic [CNT_WIDTH-1:0] count;
    logic [CNT_WIDTH-1:0] count_nxt;
    logic                 sat;
    logic                 sat_nxt;
    logic                 load;
    logic                 fold;
    logic                 latch;
    logic [SIG_WIDTH-1:0] sig_nxt;

    assign start_edge = ap_start & ~start_q;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state   <= IDLE;
            start_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            start_q <= ap_start;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start_edge) state_nxt = RUN;
            RUN:        if (ap_done) state_nxt = DRAIN;
            DRAIN:      if (drain_cnt == '0) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load  = 1'b0;
        fold  = 1'b0;
        latch = 1'b0;
        case (state)
            IDLE, DONE: load = start_edge;
            RUN:        fold = data_valid;
            DRAIN: begin
                fold  = data_valid;
                latch = (drain_cnt == '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            drain_cnt <= '0;
        end else if (state == RUN && ap_done) begin
            drain_cnt <= DRAIN_LOAD;
        end else if (state == DRAIN && drain_cnt != '0) begin
            drain_cnt <= drain_cnt - 1'b1;
        end
    end

    // Counter sticks at all-ones; any beat beyond that marks the run as saturated.
    always_comb begin
        count_nxt = count;
        sat_nxt   = sat;
        if (load) begin
            count_nxt = '0;
            sat_nxt   = 1'b0;
        end else if (fold) begin
            if (&count) begin
                sat_nxt = 1'b1;
            end else begin
                count_nxt = count + 1'b1;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            count <= '0;
            sat   <= 1'b0;
        end else begin
            count <= count_nxt;
            sat   <= sat_nxt;
        end
    end

    sig_misr #(
        .SIG_WIDTH (SIG_WIDTH),
        .POLY      (POLY),
        .SEED      (SEED)
    ) u_misr (
        .clk      (ap_clk),
        .rst_n    (ap_rst_n),
        .load     (load),
        .en       (fold),
        .nibble   (data_out),
        .sig_next (sig_nxt)
    );

    // Latch from the next-values so a beat on the last drain cycle is included.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            sig_out   <= '0;
            beat_cnt  <= '0;
            sig_valid <= 1'b0;
            cnt_err   <= 1'b0;
            busy      <= 1'b0;
            run_cnt   <= '0;
        end else begin
            busy <= (state_nxt == RUN) || (state_nxt == DRAIN);
            if (load) begin
                sig_valid <= 1'b0;
            end
            if (latch) begin
                sig_out   <= sig_nxt;
                beat_cnt  <= count_nxt;
                sig_valid <= 1'b1;
                cnt_err   <= (CHECK_EN && (count_nxt != EXP_CNT)) || sat_nxt;
                run_cnt   <= run_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_out_sig_collector.sv
// Scoreboard bench for out_sig_collector: three instances (defaults, expected-count
// check, narrow counter) share one randomized stimulus and are checked per run.
module tb_out_sig_collector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ap_start;
    logic        ap_done;
    logic        dv;
    logic [3:0]  dout;

    logic [31:0] sig_a, sig_b, sig_c;
    logic [15:0] bc_a, bc_b;
    logic [3:0]  bc_c;
    logic        sv_a, sv_b, sv_c;
    logic        err_a, err_b, err_c;
    logic        busy_a, busy_b, busy_c;
    logic [7:0]  rc_a, rc_b, rc_c;

    always #5 clk = ~clk;

    out_sig_collector u_a (
        .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(ap_start), .ap_done(ap_done),
        .data_valid(dv), .data_out(dout), .sig_out(sig_a), .beat_cnt(bc_a),
        .sig_valid(sv_a), .cnt_err(err_a), .busy(busy_a), .run_cnt(rc_a)
    );

    out_sig_collector #(.EXPECTED_BEATS(4096)) u_b (
        .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(ap_start), .ap_done(ap_done),
        .data_valid(dv), .data_out(dout), .sig_out(sig_b), .beat_cnt(bc_b),
        .sig_valid(sv_b), .cnt_err(err_b), .busy(busy_b), .run_cnt(rc_b)
    );

    out_sig_collector #(.CNT_WIDTH(4)) u_c (
        .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(ap_start), .ap_done(ap_done),
        .data_valid(dv), .data_out(dout), .sig_out(sig_c), .beat_cnt(bc_c),
        .sig_valid(sv_c), .cnt_err(err_c), .busy(busy_c), .run_cnt(rc_c)
    );

    typedef struct {
        logic [31:0] sig;
        int          n;
        int          rc;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    logic [3:0]  nibs[$];
    int          checks    = 0;
    int          failures  = 0;
    int          cyc       = 0;
    int          fixed_nib = -1;
    int          rc_model  = 0;
    logic        pa = 1'b0, pb = 1'b0, pc = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int clip(input int n, input int maxv);
        return (n > maxv) ? maxv : n;
    endfunction

    // Reference signature of the current run, computed from the folded nibble list.
    function automatic logic [31:0] ref_sig();
        logic [31:0] s;
        s = 32'hFFFFFFFF;
        foreach (nibs[i]) s = ((s << 1) ^ (s[31] ? 32'h04C11DB7 : 32'h0)) ^ {28'h0, nibs[i]};
        return s;
    endfunction

    // Monitor: any rising sig_valid must match the oldest expected run result.
    always @(negedge clk) begin
        if ((sv_a && !pa) || (sv_b && !pb) || (sv_c && !pc)) begin
            chk("latch_expected", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
                chk("latch_cycle", 64'(cyc), 64'(q[0].cyc));
                chk("sv_a", sv_a, 1);
                chk("sv_b", sv_b, 1);
                chk("sv_c", sv_c, 1);
                chk("sig_a", sig_a, q[0].sig);
                chk("sig_b", sig_b, q[0].sig);
                chk("sig_c", sig_c, q[0].sig);
                chk("beats_a", bc_a, 64'(clip(q[0].n, 65535)));
                chk("beats_b", bc_b, 64'(clip(q[0].n, 65535)));
                chk("beats_c", bc_c, 64'(clip(q[0].n, 15)));
                chk("err_a", err_a, 64'(q[0].n > 65535));
                chk("err_b", err_b, 64'(q[0].n != 4096 || q[0].n > 65535));
                chk("err_c", err_c, 64'(q[0].n > 15));
                chk("run_cnt_a", rc_a, 64'(q[0].rc % 256));
                chk("run_cnt_b", rc_b, 64'(q[0].rc % 256));
                chk("run_cnt_c", rc_c, 64'(q[0].rc % 256));
                void'(q.pop_front());
            end
        end
        pa <= sv_a;
        pb <= sv_b;
        pc <= sv_c;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input bit v, input bit counted);
        dv   = v;
        dout = (fixed_nib >= 0) ? fixed_nib[3:0] : 4'($urandom);
        if (v && counted) nibs.push_back(dout);
    endtask

    // One kernel run: idle lead-in, start edge, RUN beats, done, 4 drain cycles, one DONE beat.
    task automatic do_run(input int n_run, input int pct, input bit done_beat,
                          input int drain_mask, input bit restart);
        ap_start = 1'b0;
        ap_done  = 1'($urandom);
        drive_beat(1'($urandom), 1'b0);
        tick();
        ap_done  = 1'b0;
        ap_start = 1'b1;
        drive_beat(1'($urandom), 1'b0);
        tick();
        chk("sv_clear_on_start", sv_a, 0);
        chk("busy_in_run", busy_a, 1);
        nibs.delete();
        for (int i = 0; i < n_run; i++) begin
            ap_start = (i < 2) || (restart && i == n_run / 2);
            drive_beat(int'($urandom_range(99, 0)) < pct, 1'b1);
            tick();
        end
        ap_start = 1'b0;
        ap_done  = 1'b1;
        drive_beat(done_beat, 1'b1);
        tick();
        ap_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_beat((drain_mask < 0) ? 1'($urandom) : drain_mask[k], 1'b1);
            if (k == 3) begin
                rc_model++;
                q.push_back('{ref_sig(), nibs.size(), rc_model, cyc + 1});
            end
            tick();
        end
        drive_beat(1'b1, 1'b0);
        tick();
        dv = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        ap_start = 1'b0;
        ap_done  = 1'b0;
        dv       = 1'b0;
        dout     = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sig", sig_a, 0);
        chk("rst_beats", bc_a, 0);
        chk("rst_valid", sv_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_busy_b", busy_b, 0);
        chk("rst_busy_c", busy_c, 0);
        chk("rst_run_cnt", rc_a, 0);
        #2 rst_n = 1'b1;
        tick();

        do_run(5, 0, 1'b0, 0, 1'b0);
        chk("zero_sig", sig_a, 32'hFFFFFFFF);
        chk("zero_beats", bc_a, 0);
        chk("zero_err", err_a, 0);
        chk("zero_valid", sv_a, 1);

        fixed_nib = 5;
        do_run(1, 100, 1'b0, 0, 1'b0);
        fixed_nib = -1;
        chk("one_sig", sig_a, 32'hFB3EE24C);
        chk("one_beats", bc_a, 1);

        do_run(3, 0, 1'b1, 8, 1'b0);
        chk("drain_beats", bc_a, 2);
        chk("drain_run_cnt", rc_a, 3);

        do_run(10, 50, 1'b0, -1, 1'b1);

        do_run(4091, 100, 1'b1, 15, 1'b0);
        chk("cnt4096_beats", bc_b, 4096);
        chk("cnt4096_err", err_b, 0);
        do_run(4090, 100, 1'b1, 15, 1'b0);
        chk("cnt4095_err", err_b, 1);

        do_run(20, 100, 1'b0, 0, 1'b0);
        chk("sat_beats", bc_c, 15);
        chk("sat_err", err_c, 1);

        repeat (6) do_run(int'($urandom_range(40, 6)), 50, 1'($urandom), -1, 1'($urandom));

        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        repeat (5) begin
            drive_beat(1'b1, 1'b0);
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_sig", sig_a, 0);
        chk("midrst_beats", bc_a, 0);
        chk("midrst_valid", sv_a, 0);
        chk("midrst_err", err_a, 0);
        chk("midrst_busy", busy_a, 0);
        chk("midrst_run_cnt", rc_a, 0);
        rc_model = 0;
        dv = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        do_run(8, 50, 1'b1, -1, 1'b0);
        chk("after_rst_run_cnt", rc_a, 1);

        repeat (3) tick();
        chk("scoreboard_drained", 64'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/out_sig_collector.md
# out_sig_collector

Downstream consumer of the kernel wrapper's 4-bit XOR-reduced output stream (`data_valid`/`data_out`). Folds every valid nibble of one kernel run into a 32-bit MISR signature and counts beats. After `ap_done` it drains the wrapper's output pipeline, then latches the signature, beat count and count-check result for readout by VIO/ILA. This lets power-measurement runs be checked for functional correctness without a full output dump.

## Interface
Parameters:
- `SIG_WIDTH`, 32: signature width.
- `CNT_WIDTH`, 16: beat counter width.
- `POLY`, 32'h04C11DB7: MISR feedback polynomial.
- `SEED`, 32'hFFFFFFFF: signature value loaded on run start.
- `EXPECTED_BEATS`, 0: expected beats per run. 0 disables the count check.
- `DRAIN_CYCLES`, 4: cycles waited after `ap_done` for in-flight output beats.

Ports:
- `ap_clk` in 1: single clock, the kernel clock.
- `ap_rst_n` in 1: asynchronous, active-low reset.
- `ap_start` in 1: kernel start level, the same signal the kernel sees. Its rising edge begins a run.
- `ap_done` in 1: kernel done pulse.
- `data_valid` in 1: output beat valid from the wrapper's reduction tree.
- `data_out` in 4: output beat value.
- `sig_out` out SIG_WIDTH: latched signature of the last completed run.
- `beat_cnt` out CNT_WIDTH: latched beat count of the last completed run.
- `sig_valid` out 1: high while `sig_out`/`beat_cnt` hold a completed run.
- `cnt_err` out 1: last run's count mismatched `EXPECTED_BEATS`, or the counter saturated.
- `busy` out 1: high in RUN or DRAIN.
- `run_cnt` out 8: completed runs, wrapping modulo 256.

## Operation
- FSM states:
  - IDLE: waiting for a run.
  - RUN: kernel executing; beats are folded.
  - DRAIN: `ap_done` seen; still folding beats for `DRAIN_CYCLES` cycles.
  - DONE: results latched.
- Transitions:
  - IDLE or DONE -> RUN on a rising edge of `ap_start` (registered `ap_start` was 0, now 1). On entry: working signature <= `SEED`, working count <= 0, `sig_valid` <= 0.
  - RUN -> DRAIN on `ap_done`=1. Drain counter loads `DRAIN_CYCLES`-1.
  - DRAIN -> DONE when the drain counter reaches 0. On entry:
    - `sig_out` <= working signature; `beat_cnt` <= working count; `sig_valid` <= 1; `run_cnt` += 1.
    - `cnt_err` <= (`EXPECTED_BEATS`≠0 and count≠`EXPECTED_BEATS`) or saturated.
- A beat is folded whenever `data_valid`=1 in RUN or DRAIN:
  - sig <= {sig[30:0],0} ^ (sig[31] ? POLY : 0) ^ zero-extended `data_out`.
  - count += 1. Count saturates at all-ones and sets the sticky saturated flag.
- Beats arriving in IDLE or DONE are ignored.
- An `ap_start` edge in RUN or DRAIN is ignored; the run is not restarted.
- `ap_done` in IDLE or DONE is ignored.
- `ap_done` and `data_valid` in the same RUN cycle: the beat is folded, and the state still moves to DRAIN.
- A beat on the final DRAIN cycle is folded and included in the latched result.
- Reset mid-run: all state is cleared and the partial run is discarded; no latch occurs.

## Timing
- Reset values: `sig_out`=0, `beat_cnt`=0, `sig_valid`=0, `cnt_err`=0, `busy`=0, `run_cnt`=0; FSM in IDLE.
- All outputs are registered.
- `ap_start` to first-foldable beat: a beat may arrive the cycle after the edge is registered. RUN is entered 1 cycle after `ap_start` rises.
- `sig_valid` rises exactly `DRAIN_CYCLES`+1 cycles after the `ap_done` cycle.
- `sig_valid` stays high until the next run start, then falls 1 cycle after the start edge.
- Throughput: one beat per cycle, no backpressure.

## Structure
- Shared package `out_sig_pkg`:
  - FSM state enum (IDLE/RUN/DRAIN/DONE).
  - Default `POLY` and `SEED` constants.
  - Pure function `misr_step(sig, nibble)`.
- One natural sub-module, `sig_misr`: the working signature register with load/enable. The FSM and counters stay in the top.

## Test plan
- Zero beats (defaults, `EXPECTED_BEATS`=0): start, done, no `data_valid` -> `sig_out`=32'hFFFFFFFF, `beat_cnt`=0, `sig_valid`=1 at done+5 cycles, `cnt_err`=0.
- One beat: `data_out`=4'h5 during RUN -> `sig_out`=32'hFB3EE24C, `beat_cnt`=1.
- Count check (`EXPECTED_BEATS`=4096):
  - 4096 beats -> `cnt_err`=0.
  - 4095 beats -> `cnt_err`=1.
  - Signature matches the reference model.
- Drain window: beats on the `ap_done` cycle and on DRAIN cycle 4 are counted; a beat 1 cycle after `sig_valid` rises is not; `run_cnt` increments by 1.
- Mid-run disturbances:
  - Second `ap_start` edge during RUN -> ignored, with no signature reload.
  - `ap_rst_n` low during RUN -> all outputs 0 immediately.
  - After reset, a clean run -> `run_cnt`=1.
- Saturation (`CNT_WIDTH`=4): 20 beats -> `beat_cnt`=15, `cnt_err`=1.
